varredura_display: RTL

Time-multiplexed scan controller for the 4-digit 7-segment display. It drives the 2-bit digit selector into the existing combinational digit multiplexer (unid/dez/agroDef/estado → segmentos) and receives the selected segment pattern back. It registers that pattern toward the pins and generates active-low digit enables with inter-digit blanking to suppress ghosting. It sits between the digit-source logic and the board display pins.

---
 rtl/varredura_display_pkg.sv | 22 ++
 rtl/varredura_display_divisor_slot.sv | 27 ++
 rtl/varredura_display.sv | 69 ++++++
 3 files changed

// File: rtl/varredura_display_pkg.sv
// Shared display definitions: digit selector encodings, blank pattern, scan FSM states.
package varredura_display_pkg;

  localparam logic [1:0] SEL_UNID   = 2'd0;
  localparam logic [1:0] SEL_DEZ    = 2'd1;
  localparam logic [1:0] SEL_AGRO   = 2'd2;
  localparam logic [1:0] SEL_ESTADO = 2'd3;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  typedef enum logic [1:0] {
    DESLIGADO,
    APAGA,
    MOSTRA
  } estado_t;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [3:0] digito_n(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/varredura_display_divisor_slot.sv
// Slot timebase: counts 0..DIV-1 and flags the blanking boundary and the end of slot.
module divisor_slot #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2,
  parameter int CW    = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc,
  output logic pre_tc,
  output logic fim_apaga
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr || tc) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

  assign tc        = (cnt == CW'(DIV - 1));
  assign pre_tc    = (cnt == CW'(DIV - 2));
  assign fim_apaga = (cnt == CW'(BLANK - 1));

endmodule

// File: rtl/varredura_display.sv
// 4-digit 7-segment scan controller with per-slot blanking and registered pin drive.
module varredura_display
  import varredura_display_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] blank_mask,
  input  logic [6:0] segmentos_in,
  output logic [1:0] seletor,
  output logic [3:0] digitos_n,
  output logic [6:0] segmentos_out,
  output logic       tick_quadro
);

  estado_t    estado, estado_d;
  logic [1:0] sel_d;
  logic       clr, tc, pre_tc, fim_apaga;

  divisor_slot #(.DIV(DIV), .BLANK(BLANK)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .tc        (tc),
    .pre_tc    (pre_tc),
    .fim_apaga (fim_apaga)
  );

  always_comb begin
    estado_d = estado;
    sel_d    = seletor;
    case (estado)
      DESLIGADO: if (enable) estado_d = APAGA;
      APAGA:     if (fim_apaga) estado_d = MOSTRA;
      MOSTRA: if (tc) begin
        estado_d = APAGA;
        sel_d    = seletor + 2'd1;
      end
      default:   estado_d = DESLIGADO;
    endcase
    // Dropping enable abandons the slot; re-enable restarts at digit 0.
    if (!enable) estado_d = DESLIGADO;
    if (estado_d == DESLIGADO) sel_d = SEL_UNID;
  end

  // Hold the counter at 0 while off and on the edge that turns the scan off.
  assign clr = (estado == DESLIGADO) || (estado_d == DESLIGADO);

  // Outputs are registered from next-state values so they line up with state/cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= DESLIGADO;
      seletor       <= SEL_UNID;
      digitos_n     <= 4'b1111;
      segmentos_out <= SEG_APAGADO;
      tick_quadro   <= 1'b0;
    end else begin
      estado        <= estado_d;
      seletor       <= sel_d;
      digitos_n     <= (estado_d == MOSTRA && !blank_mask[sel_d]) ? digito_n(sel_d) : 4'b1111;
      segmentos_out <= (estado_d == DESLIGADO) ? SEG_APAGADO : segmentos_in;
      tick_quadro   <= (estado == MOSTRA) && enable && (seletor == SEL_ESTADO) && pre_tc;
    end
  end

endmodule
